seq_counter: RTL and testbench

SEQ_COUNTER -- requirements
Module: seq_counter

---
 rtl/seq_counter_pkg.sv | 21 ++
 rtl/seq_counter_core.sv | 32 +++
 rtl/seq_counter.sv | 91 +++++++++
 tb/tb_seq_counter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/seq_counter_pkg.sv
// seq_counter_pkg: shared types and constants for the seq_counter block.
//   state_t    - FSM state encoding (IDLE, RUN, DONE)
//   ctr_op_t   - command from the FSM to the count register
//   SEQ_WIDTH  - default width of count and last
package seq_counter_pkg;

   localparam int SEQ_WIDTH = 6;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      CTR_CLEAR = 2'b00,
      CTR_HOLD  = 2'b01,
      CTR_INC   = 2'b10
   } ctr_op_t;

endpackage

// File: rtl/seq_counter_core.sv
// seq_counter_core: count register that clears, holds or increments on command.
//   clk    in   rising-edge clock
//   rstn   in   asynchronous active-low reset, clears count
//   op     in   ctr_op_t command applied at the next clk edge
//   count  out  registered count value
module seq_counter_core
   import seq_counter_pkg::*;
#(
   parameter int WIDTH = SEQ_WIDTH
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = (op == CTR_INC)  ? count_q + WIDTH'(1) :
                (op == CTR_HOLD) ? count_q : '0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/seq_counter.sv
// seq_counter: start-triggered counter sequencer with one-shot and auto-restart modes.
//   clk           in   rising-edge clock
//   rstn          in   asynchronous active-low reset
//   enable        in   advance gate, sampled each clk
//   start         in   single-cycle (re)start request; latches last and auto_restart
//   last          in   terminal count value
//   auto_restart  in   1 = wrap continuously, 0 = one-shot
//   count         out  registered current count
//   busy          out  high while in RUN
//   tc            out  combinational terminal-count strobe
//   done          out  one-cycle completion pulse after a one-shot sequence
// Build option: SEQ_COUNTER_HOLD_EN makes enable=0 hold the count in RUN;
// without it enable=0 clears the count (legacy clear-on-disable).
module seq_counter
   import seq_counter_pkg::*;
#(
   parameter int WIDTH = SEQ_WIDTH
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             enable,
   input  logic             start,
   input  logic [WIDTH-1:0] last,
   input  logic             auto_restart,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tc,
   output logic             done
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] last_q, last_d;
   logic             mode_q, mode_d;
   logic [1:0]       ctr_op;

   assign tc   = (state_q == RUN) & enable & (count == last_q) & ~start;
   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      mode_d  = mode_q;
      ctr_op  = CTR_CLEAR;
      if (start) begin
         state_d = RUN;
         last_d  = last;
         mode_d  = auto_restart;
      end else begin
         case (state_q)
            RUN: begin
               if (!enable) begin
`ifdef SEQ_COUNTER_HOLD_EN
                  ctr_op = CTR_HOLD;
`else
                  ctr_op = CTR_CLEAR;
`endif
               end else if (tc) begin
                  // one-shot parks on last_q for the DONE cycle; auto wraps to 0
                  ctr_op  = mode_q ? CTR_CLEAR : CTR_HOLD;
                  state_d = mode_q ? RUN : DONE;
               end else begin
                  ctr_op = CTR_INC;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         last_q  <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         mode_q  <= mode_d;
      end
   end

   seq_counter_core #(.WIDTH(WIDTH)) u_core (
      .clk   (clk),
      .rstn  (rstn),
      .op    (ctr_op),
      .count (count)
   );

endmodule

// File: tb/tb_seq_counter.sv
// tb_seq_counter: randomized and directed scoreboard bench for seq_counter.
module tb_seq_counter;

   logic       clk = 1'b0;
   logic       rstn = 1'b1;
   logic       enable = 1'b0;
   logic       start = 1'b0;
   logic [5:0] last = '0;
   logic       auto_restart = 1'b0;
   logic [5:0] count;
   logic       busy, tc, done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string tag;
      int    cnt;
      bit    busy;
      bit    tc;
      bit    done;
   } exp_t;

   exp_t  sb[$];
   exp_t  mon_e;
   string tag = "init";

   bit m_run = 0, m_done = 0, m_auto = 0;
   int m_count = 0, m_last = 0;

   seq_counter #(.WIDTH(6)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .enable       (enable),
      .start        (start),
      .last         (last),
      .auto_restart (auto_restart),
      .count        (count),
      .busy         (busy),
      .tc           (tc),
      .done         (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         chk({mon_e.tag, ".count"}, int'(count), mon_e.cnt);
         chk({mon_e.tag, ".busy"},  int'(busy),  int'(mon_e.busy));
         chk({mon_e.tag, ".tc"},    int'(tc),    int'(mon_e.tc));
         chk({mon_e.tag, ".done"},  int'(done),  int'(mon_e.done));
      end
   end

   function automatic void push_exp(input bit en, input bit st);
      exp_t e;
      e.tag  = tag;
      e.cnt  = m_count;
      e.busy = m_run;
      e.done = m_done;
      e.tc   = m_run && en && !st && (m_count == m_last);
      sb.push_back(e);
   endfunction

   // One clock cycle: drive inputs, predict this cycle's outputs, then
   // advance the reference model across the coming edge.
   task automatic cyc(input bit en, input bit st, input int l, input bit ar);
      @(posedge clk); #1;
      enable = en; start = st; last = 6'(l); auto_restart = ar;
      push_exp(en, st);
      if (st) begin
         m_run = 1; m_done = 0; m_count = 0; m_last = l; m_auto = ar;
      end else if (m_done) begin
         m_done = 0; m_count = 0;
      end else if (m_run) begin
         if (!en) begin
`ifndef SEQ_COUNTER_HOLD_EN
            m_count = 0;
`endif
         end else if (m_count == m_last) begin
            if (m_auto) m_count = 0;
            else begin m_run = 0; m_done = 1; end
         end else begin
            m_count = m_count + 1;
         end
      end
   endtask

   task automatic mid_reset();
      @(posedge clk); #1;
      rstn = 1'b0; start = 1'b0; enable = 1'b0;
      m_run = 0; m_done = 0; m_count = 0; m_last = 0; m_auto = 0;
      push_exp(0, 0);
      #1;
      chk({tag, ".async_count"}, int'(count), 0);
      chk({tag, ".async_busy"},  int'(busy),  0);
      chk({tag, ".async_done"},  int'(done),  0);
      chk({tag, ".async_tc"},    int'(tc),    0);
      @(posedge clk); #1;
      push_exp(0, 0);
      rstn = 1'b1;
   endtask

   initial begin
      #1 rstn = 1'b0;
      #1;
      chk("por.count", int'(count), 0);
      chk("por.busy",  int'(busy),  0);
      chk("por.tc",    int'(tc),    0);
      chk("por.done",  int'(done),  0);
      @(posedge clk); #1 rstn = 1'b1;

      tag = "idle";
      repeat (3) cyc(1, 0, 5, 1);

      tag = "oneshot";
      cyc(1, 1, 3, 0);
      repeat (7) cyc(1, 0, $urandom_range(0, 63), $urandom_range(0, 1));

      tag = "auto";
      cyc(1, 1, 2, 1);
      repeat (9) cyc(1, 0, $urandom_range(0, 63), 0);

      tag = "en_drop";
      cyc(1, 1, 9, 0);
      repeat (4) cyc(1, 0, 9, 0);
      repeat (2) cyc(0, 0, 9, 0);
      repeat (12) cyc(1, 0, 9, 0);

      tag = "full_range";
      cyc(1, 1, 63, 1);
      repeat (66) cyc(1, 0, 0, 0);

      tag = "last0_auto";
      cyc(1, 1, 0, 1);
      repeat (4) cyc(1, 0, 7, 0);
      cyc(0, 0, 7, 0);
      repeat (2) cyc(1, 0, 7, 0);

      tag = "last0_oneshot";
      cyc(1, 1, 0, 0);
      repeat (3) cyc(1, 0, 0, 0);

      tag = "restart";
      cyc(1, 1, 20, 0);
      repeat (8) cyc(1, 0, 20, 0);
      cyc(1, 1, 10, 0);
      repeat (14) cyc(1, 0, 33, 1);

      tag = "restart_done";
      cyc(1, 1, 1, 0);
      repeat (2) cyc(1, 0, 1, 0);
      cyc(1, 1, 2, 1);
      repeat (4) cyc(1, 0, 2, 0);

      tag = "rst_mid";
      cyc(1, 1, 8, 0);
      repeat (4) cyc(1, 0, 8, 0);
      mid_reset();
      repeat (3) cyc(1, 0, 8, 1);

      tag = "random";
      for (int i = 0; i < 600; i++) begin
         int l;
         l = ($urandom_range(0, 4) == 0) ? (($urandom_range(0, 1) == 1) ? 63 : 0)
                                          : int'($urandom_range(0, 12));
         if ($urandom_range(0, 199) == 0) mid_reset();
         else cyc($urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0,
                  l, $urandom_range(0, 1) == 1);
      end

      repeat (2) @(negedge clk);
      chk("sb_drain", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
